// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - segmented, pipelined add/subtract unit with valid/ready handshake
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_param
        $error("pipelined_addsub: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
    end

    logic              adv;
    logic [WIDTH-1:0]  bb;
    logic              cin;
    logic [STAGES-1:0] v;
    logic              ovf_q;

    // Per-stage operand/carry views and the registered carry of each segment adder.
    logic [SEG-1:0]    stage_a   [STAGES];
    logic [SEG-1:0]    stage_b   [STAGES];
    logic              stage_c   [STAGES];
    logic [SEG:0]      stage_sum [STAGES];
    logic              carry_q   [STAGES];

    // One global stall: the whole pipeline moves only when the output slot is free or draining.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Subtraction is A + ~B + ~ci, so borrow-in maps to an inverted carry-in.
    assign bb        = sub ? ~b : b;
    assign cin       = sub ? ~ci : ci;

    assign out_valid = v[STAGES-1];
    assign co        = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    // Valid bits shift with the data; bubbles travel through unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (adv) begin
            v[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v[k] <= v[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        // res_q[0] is the segment adder register; the rest align it with the last segment.
        logic [SEG-1:0] res_q [STAGES-k];

        if (k == 0) begin : g_head
            assign stage_a[k] = a[SEG-1:0];
            assign stage_b[k] = bb[SEG-1:0];
            assign stage_c[k] = cin;
        end else begin : g_skew
            logic [SEG-1:0] a_dly [k];
            logic [SEG-1:0] b_dly [k];

            // Delay this segment's operands k cycles so they meet the carry from stage k-1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        a_dly[j] <= '0;
                        b_dly[j] <= '0;
                    end
                end else if (adv) begin
                    a_dly[0] <= a[k*SEG +: SEG];
                    b_dly[0] <= bb[k*SEG +: SEG];
                    for (int j = 1; j < k; j++) begin
                        a_dly[j] <= a_dly[j-1];
                        b_dly[j] <= b_dly[j-1];
                    end
                end
            end

            assign stage_a[k] = a_dly[k-1];
            assign stage_b[k] = b_dly[k-1];
            assign stage_c[k] = carry_q[k-1];
        end

        assign stage_sum[k] = {1'b0, stage_a[k]} + {1'b0, stage_b[k]} + {{SEG{1'b0}}, stage_c[k]};

        // Segment adder register followed by the result skew line.
        always_ff @(posedge clk) begin
            if (rst) begin
                carry_q[k] <= 1'b0;
                for (int j = 0; j < STAGES - k; j++) begin
                    res_q[j] <= '0;
                end
            end else if (adv) begin
                carry_q[k] <= stage_sum[k][SEG];
                res_q[0]   <= stage_sum[k][SEG-1:0];
                for (int j = 1; j < STAGES - k; j++) begin
                    res_q[j] <= res_q[j-1];
                end
            end
        end

        assign s[k*SEG +: SEG] = res_q[STAGES-k-1];
    end

    // Signed overflow is resolved in the MSB stage, where the top operand bits and sum bit coexist.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (stage_a[STAGES-1][SEG-1] == stage_b[STAGES-1][SEG-1]) &&
                     (stage_sum[STAGES-1][SEG-1] != stage_a[STAGES-1][SEG-1]);
        end
    end
endmodule
